// File: rtl/async_elastic_fifo.sv
// Elastic token buffer between two dataflow operators. The upstream side requests tokens with
// req_l/ack_l; the downstream side hands them out as single-cycle ack_r pulses with dout.
module async_elastic_fifo #(
    parameter int unsigned data_width  = 32,
    parameter int unsigned depth       = 4,
    parameter int unsigned output_size = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         req_l,
    input  logic                         ack_l,
    input  logic [data_width-1:0]        din,
    input  logic [output_size-1:0]       req_r,
    output logic                         ack_r,
    output logic [data_width-1:0]        dout,
    output logic [$clog2(depth+1)-1:0]   count
);

    localparam int unsigned CntW = $clog2(depth + 1);
    localparam int unsigned PtrW = (depth > 1) ? $clog2(depth) : 1;
    localparam logic [CntW-1:0] Full    = CntW'(depth);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(depth - 1);

    logic [data_width-1:0] mem_q [depth];
    logic [PtrW-1:0]       wp_q, wp_d;
    logic [PtrW-1:0]       rp_q, rp_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  req_l_q, req_l_d;
    logic                  ack_r_q, ack_r_d;
    logic [data_width-1:0] dout_q, dout_d;
    logic                  ovf_q, ovf_d;
    logic                  push;
    logic                  pop;

    // Next-state logic for both handshake sides and the occupancy counter
    always_comb begin
        // An ack while full is a protocol error: the token is dropped, not written
        push    = ack_l && (count_q != Full);
        // ack_r_q blocks back-to-back pops so each ack_r is a lone pulse
        pop     = (count_q != '0) && (&req_r) && !ack_r_q;

        req_l_d = req_l_q;
        ovf_d   = ovf_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        dout_d  = dout_q;
        ack_r_d = pop;
        count_d = count_q;

        // req_l only drops on ack, never because the buffer filled meanwhile
        if (ack_l) begin
            req_l_d = 1'b0;
        end else if (!req_l_q && (count_q < Full)) begin
            req_l_d = 1'b1;
        end

        if (ack_l && (count_q == Full)) begin
            ovf_d = 1'b1;
        end

        if (push) begin
            wp_d = (wp_q == LastPtr) ? '0 : wp_q + 1'b1;
        end

        if (pop) begin
            rp_d   = (rp_q == LastPtr) ? '0 : rp_q + 1'b1;
            dout_d = mem_q[rp_q];
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Token storage; contents are don't-care after reset so no reset is applied
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wp_q] <= din;
        end
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_l_q <= 1'b0;
            ack_r_q <= 1'b0;
            dout_q  <= '0;
            count_q <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            req_l_q <= req_l_d;
            ack_r_q <= ack_r_d;
            dout_q  <= dout_d;
            count_q <= count_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            ovf_q   <= ovf_d;
        end
    end

    assign req_l = req_l_q;
    assign ack_r = ack_r_q;
    assign dout  = dout_q;
    assign count = count_q;

endmodule

// File: tb/tb_async_elastic_fifo.sv
// Directed bench for async_elastic_fifo: a vector table for fill/drain/reset plus
// hand-written sequences for streaming, overflow detection and fan-out with depth 1.
module tb_async_elastic_fifo;

    logic        clk;
    logic        rst;
    logic        req_l;
    logic        ack_l;
    logic [31:0] din;
    logic [0:0]  req_r;
    logic        ack_r;
    logic [31:0] dout;
    logic [2:0]  count;

    logic        rst2;
    logic        req_l2;
    logic        ack_l2;
    logic [7:0]  din2;
    logic [1:0]  req_r2;
    logic        ack_r2;
    logic [7:0]  dout2;
    logic [0:0]  count2;

    int n_vec;
    int n_bad;

    async_elastic_fifo #(
        .data_width  (32),
        .depth       (4),
        .output_size (1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req_l (req_l),
        .ack_l (ack_l),
        .din   (din),
        .req_r (req_r),
        .ack_r (ack_r),
        .dout  (dout),
        .count (count)
    );

    async_elastic_fifo #(
        .data_width  (8),
        .depth       (1),
        .output_size (2)
    ) dut2 (
        .clk   (clk),
        .rst   (rst2),
        .req_l (req_l2),
        .ack_l (ack_l2),
        .din   (din2),
        .req_r (req_r2),
        .ack_r (ack_r2),
        .dout  (dout2),
        .count (count2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        ack;
        logic [31:0] din;
        logic        req_r;
        logic        e_req;
        logic        e_ack;
        logic [31:0] e_dout;
        int          e_cnt;
        int          e_wp;   // -1: pointers not checked
        int          e_rp;
    } vec_t;

    vec_t vecs[35];

    function automatic vec_t mk(logic r, logic a, int d, logic rr, logic er, logic ea, int ed,
                                int ec, int ewp, int erp);
        vec_t v;
        v.rst = r; v.ack = a; v.din = 32'(d); v.req_r = rr;
        v.e_req = er; v.e_ack = ea; v.e_dout = 32'(ed); v.e_cnt = ec;
        v.e_wp = ewp; v.e_rp = erp;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int sent, got, bad, maxc, first, last, k;
        n_vec = 0;
        n_bad = 0;
        rst = 1'b0; ack_l = 1'b0; din = '0; req_r = '0;
        rst2 = 1'b0; ack_l2 = 1'b0; din2 = '0; req_r2 = '0;

        //            rst ack din rr | req ack dout cnt | wp rp
        vecs[0]  = mk(0, 0,  0, 0,   0, 0,  0, 0,    0,  0);
        vecs[1]  = mk(1, 0,  0, 0,   1, 0,  0, 0,   -1, -1);
        vecs[2]  = mk(1, 1, 10, 0,   0, 0,  0, 1,   -1, -1);
        vecs[3]  = mk(1, 0,  0, 0,   1, 0,  0, 1,   -1, -1);
        vecs[4]  = mk(1, 1, 11, 0,   0, 0,  0, 2,   -1, -1);
        vecs[5]  = mk(1, 0,  0, 0,   1, 0,  0, 2,   -1, -1);
        vecs[6]  = mk(1, 1, 12, 0,   0, 0,  0, 3,   -1, -1);
        vecs[7]  = mk(1, 0,  0, 0,   1, 0,  0, 3,   -1, -1);
        vecs[8]  = mk(1, 1, 13, 0,   0, 0,  0, 4,    0,  0);
        vecs[9]  = mk(1, 0, 14, 0,   0, 0,  0, 4,   -1, -1);
        vecs[10] = mk(1, 0, 14, 0,   0, 0,  0, 4,   -1, -1);
        vecs[11] = mk(1, 0, 14, 1,   0, 1, 10, 3,   -1, -1);
        vecs[12] = mk(1, 0, 14, 1,   1, 0, 10, 3,   -1, -1);
        vecs[13] = mk(1, 1, 14, 1,   0, 1, 11, 3,    1,  2);
        vecs[14] = mk(1, 0,  0, 1,   1, 0, 11, 3,   -1, -1);
        vecs[15] = mk(1, 0,  0, 1,   1, 1, 12, 2,   -1, -1);
        vecs[16] = mk(1, 0,  0, 1,   1, 0, 12, 2,   -1, -1);
        vecs[17] = mk(1, 0,  0, 1,   1, 1, 13, 1,   -1, -1);
        vecs[18] = mk(1, 0,  0, 1,   1, 0, 13, 1,   -1, -1);
        vecs[19] = mk(1, 0,  0, 1,   1, 1, 14, 0,    1,  1);
        vecs[20] = mk(1, 0,  0, 1,   1, 0, 14, 0,   -1, -1);
        vecs[21] = mk(1, 0,  0, 1,   1, 0, 14, 0,   -1, -1);
        vecs[22] = mk(1, 1, 20, 0,   0, 0, 14, 1,   -1, -1);
        vecs[23] = mk(1, 0,  0, 0,   1, 0, 14, 1,   -1, -1);
        vecs[24] = mk(1, 1, 21, 0,   0, 0, 14, 2,    3,  1);
        vecs[25] = mk(1, 0,  0, 0,   1, 0, 14, 2,   -1, -1);
        // push and pop together at count 2
        vecs[26] = mk(1, 1, 22, 1,   0, 1, 20, 2,    0,  2);
        vecs[27] = mk(1, 0,  0, 0,   1, 0, 20, 2,   -1, -1);
        vecs[28] = mk(1, 1, 23, 0,   0, 0, 20, 3,   -1, -1);
        vecs[29] = mk(1, 0,  0, 0,   1, 0, 20, 3,   -1, -1);
        // reset with three tokens held and a request outstanding
        vecs[30] = mk(0, 0,  0, 0,   0, 0,  0, 0,    0,  0);
        vecs[31] = mk(1, 0,  0, 0,   1, 0,  0, 0,   -1, -1);
        vecs[32] = mk(1, 1, 30, 0,   0, 0,  0, 1,   -1, -1);
        vecs[33] = mk(1, 0,  0, 1,   1, 1, 30, 0,   -1, -1);
        vecs[34] = mk(1, 0,  0, 0,   1, 0, 30, 0,    1,  1);

        for (int i = 0; i < 35; i++) begin
            rst = vecs[i].rst; ack_l = vecs[i].ack; din = vecs[i].din; req_r = vecs[i].req_r;
            tick;
            check($sformatf("v%0d req_l", i), 64'(req_l), 64'(vecs[i].e_req));
            check($sformatf("v%0d ack_r", i), 64'(ack_r), 64'(vecs[i].e_ack));
            check($sformatf("v%0d dout", i), 64'(dout), 64'(vecs[i].e_dout));
            check($sformatf("v%0d count", i), 64'(count), 64'(vecs[i].e_cnt));
            if (vecs[i].e_wp >= 0) begin
                check($sformatf("v%0d wp", i), 64'(dut.wp_q), 64'(vecs[i].e_wp));
                check($sformatf("v%0d rp", i), 64'(dut.rp_q), 64'(vecs[i].e_rp));
            end
        end
        check("no_ovf_after_vectors", 64'(dut.ovf_q), 64'd0);

        // Steady stream: both sides always ready
        ack_l = 1'b0; req_r = 1'b0; rst = 1'b0;
        tick;
        rst = 1'b1; req_r = 1'b1;
        sent = 0; got = 0; bad = 0; maxc = 0; first = -1; last = -1;
        for (int cyc = 0; cyc < 12000 && got < 5000; cyc++) begin
            if (req_l && sent < 5000) begin
                ack_l = 1'b1; din = 32'(sent); sent++;
            end else begin
                ack_l = 1'b0;
            end
            tick;
            if (ack_r) begin
                if (dout !== 32'(got)) bad++;
                if (got == 0) first = cyc;
                last = cyc;
                got++;
            end
            if (int'(count) > maxc) maxc = int'(count);
        end
        ack_l = 1'b0;
        check("stream_tokens_out", 64'(got), 64'd5000);
        check("stream_order_errors", 64'(bad), 64'd0);
        check("stream_count_le_2", 64'(maxc <= 2), 64'd1);
        check("stream_span_cycles", 64'(last - first), 64'(2 * 4999));

        // Protocol-error ack while full: flagged and dropped
        rst = 1'b0; req_r = 1'b0;
        tick;
        rst = 1'b1;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            if (req_l && k < 4) begin
                ack_l = 1'b1; din = 32'(40 + k); k++;
            end else begin
                ack_l = 1'b0;
            end
            tick;
        end
        check("ovf_fill_count", 64'(count), 64'd4);
        check("ovf_clear_before", 64'(dut.ovf_q), 64'd0);
        ack_l = 1'b1; din = 32'd99;
        tick;
        ack_l = 1'b0;
        check("ovf_set", 64'(dut.ovf_q), 64'd1);
        check("ovf_count_held", 64'(count), 64'd4);
        req_r = 1'b1; got = 0; bad = 0;
        for (int c = 0; c < 12; c++) begin
            tick;
            if (ack_r) begin
                if (dout !== 32'(40 + got)) bad++;
                got++;
            end
        end
        check("ovf_drain_tokens", 64'(got), 64'd4);
        check("ovf_drain_order", 64'(bad), 64'd0);
        req_r = 1'b0;

        // Fan-out of two with depth 1
        rst2 = 1'b0;
        tick;
        rst2 = 1'b1; req_r2 = 2'b01;
        sent = 0; got = 0; bad = 0; maxc = 0; first = -1; k = 0;
        for (int c = 0; c < 5; c++) begin
            if (req_l2 && sent < 3) begin
                ack_l2 = 1'b1; din2 = 8'(8'hA5 + sent); sent++;
            end else begin
                ack_l2 = 1'b0;
            end
            tick;
            if (ack_r2) k++;
            if (int'(count2) > maxc) maxc = int'(count2);
        end
        check("fan_no_ack_partial_req", 64'(k), 64'd0);
        check("fan_token_held", 64'(count2), 64'd1);
        req_r2 = 2'b11;
        for (int c = 0; c < 12; c++) begin
            if (req_l2 && sent < 3) begin
                ack_l2 = 1'b1; din2 = 8'(8'hA5 + sent); sent++;
            end else begin
                ack_l2 = 1'b0;
            end
            tick;
            if (ack_r2) begin
                if (first < 0) first = c;
                if (dout2 !== 8'(8'hA5 + got)) bad++;
                got++;
            end
            if (int'(count2) > maxc) maxc = int'(count2);
        end
        ack_l2 = 1'b0;
        check("fan_first_ack_latency", 64'(first >= 0 && first <= 2), 64'd1);
        check("fan_tokens_out", 64'(got), 64'd3);
        check("fan_order", 64'(bad), 64'd0);
        check("fan_count_le_1", 64'(maxc <= 1), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
